// File: rtl/adc_spi_responder_pkg.sv
// Shared types and constants for the ADC SPI responder.
// State encoding, default widths and channel power-on values live here.
package adc_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_TAIL = 2'd3
  } state_e;

  localparam int CMD_W_DEF  = 8;
  localparam int DATA_W_DEF = 16;
  localparam int FRAME_BITS = CMD_W_DEF + DATA_W_DEF;

  localparam logic [15:0] CH0_RST = 16'h1234;
  localparam logic [15:0] CH1_RST = 16'h5678;
  localparam logic [15:0] CH2_RST = 16'h9ABC;
  localparam logic [15:0] CH3_RST = 16'hDEF0;

endpackage

// File: rtl/adc_spi_responder_sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous input, with single-clk
// rise/fall pulses derived from the synchronized level.
module sync_edge_det #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = (sync_q << 1) | STAGES'(din);
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI mode-0 responder emulating a 4-channel ADC: command in, sample out.
// Define ADC_RESP_RAMP_EN to make each served channel count up per frame.
module adc_spi_responder
  import adc_resp_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int CMD_W       = CMD_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic              ld_valid,
  input  logic [1:0]        ld_ch,
  input  logic [DATA_W-1:0] ld_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic [CMD_W-1:0]  last_cmd,
  output state_e            dbg_state
);

  localparam int CNT_W   = $clog2(CMD_W + DATA_W);
  localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_edges;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .din(sck), .level(sck_s), .rise(sck_rise), .fall(sck_fall));
  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs_n), .level(cs_s), .rise(cs_rise), .fall(cs_fall));
  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi), .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

  assign unused_edges = ^{sck_s, mosi_rise, mosi_fall};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CMD_W-1:0]  cmd_sr_q, cmd_sr_d, cmd_next;
  logic [CMD_W-1:0]  last_cmd_q, last_cmd_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              miso_bit_q, miso_bit_d;
  logic [1:0]        sel_q, sel_d;
  logic              done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0] chan_q [4];
  logic [DATA_W-1:0] chan_d [4];
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic              armed_q, armed_d;
  logic              flushed, done_evt;

  // Only a real high-to-low cs_n transition may start a frame: the synchronizer
  // reset value must be flushed and cs_n seen high before arming.
  assign flushed  = (flush_q == FLUSH_W'(SYNC_STAGES + 1));
  assign done_evt = (state_q == ST_TAIL) && cs_rise;

  always_comb begin
    flush_d = flushed ? flush_q : flush_q + 1'b1;
    armed_d = armed_q | (flushed & cs_s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cmd_sr_q   <= '0;
      last_cmd_q <= '0;
      shift_q    <= '0;
      miso_bit_q <= 1'b0;
      sel_q      <= 2'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      flush_q    <= '0;
      armed_q    <= 1'b0;
      chan_q[0]  <= DATA_W'(CH0_RST);
      chan_q[1]  <= DATA_W'(CH1_RST);
      chan_q[2]  <= DATA_W'(CH2_RST);
      chan_q[3]  <= DATA_W'(CH3_RST);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_sr_q   <= cmd_sr_d;
      last_cmd_q <= last_cmd_d;
      shift_q    <= shift_d;
      miso_bit_q <= miso_bit_d;
      sel_q      <= sel_d;
      done_q     <= done_d;
      err_q      <= err_d;
      flush_q    <= flush_d;
      armed_q    <= armed_d;
      for (int i = 0; i < 4; i++) chan_q[i] <= chan_d[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_sr_d   = cmd_sr_q;
    last_cmd_d = last_cmd_q;
    shift_d    = shift_q;
    miso_bit_d = miso_bit_q;
    sel_d      = sel_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cmd_next   = {cmd_sr_q[CMD_W-2:0], mosi_s};
    case (state_q)
      ST_IDLE: begin
        miso_bit_d = 1'b0;
        if (cs_fall && armed_q) begin
          state_d  = ST_CMD;
          cnt_d    = '0;
          cmd_sr_d = '0;
        end
      end
      ST_CMD: begin
        if (cs_rise) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (sck_rise) begin
          cmd_sr_d = cmd_next;
          if (cnt_q == CNT_W'(CMD_W - 1)) begin
            last_cmd_d = cmd_next;
            sel_d      = cmd_next[1:0];
            shift_d    = chan_q[cmd_next[1:0]];
            miso_bit_d = chan_q[cmd_next[1:0]][DATA_W-1];
            cnt_d      = '0;
            state_d    = ST_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (cs_rise) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (sck_rise) begin
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            miso_bit_d = 1'b0;
            state_d    = ST_TAIL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (sck_fall && cnt_q != '0) begin
          // The fall just after the last command edge keeps the MSB on the line.
          shift_d    = shift_q << 1;
          miso_bit_d = shift_q[DATA_W-2];
        end
      end
      ST_TAIL: begin
        miso_bit_d = 1'b0;
        if (cs_rise) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) chan_d[i] = chan_q[i];
`ifdef ADC_RESP_RAMP_EN
    if (done_evt) chan_d[sel_q] = chan_q[sel_q] + 1'b1;
`else
    if (done_evt) chan_d[sel_q] = chan_q[sel_q];
`endif
    if (ld_valid) chan_d[ld_ch] = ld_data;
  end

  always_comb begin
    miso       = (state_q == ST_DATA) & miso_bit_q;
    frame_done = done_q;
    frame_err  = err_q;
    last_cmd   = last_cmd_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: frames driven at sck = clk/10,
// sample words and frame pulses checked against hand-computed values.
module tb_adc_spi_responder;
  import adc_resp_pkg::*;

`ifdef ADC_RESP_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic        clk, rst, sck, cs_n, mosi, miso;
  logic        ld_valid;
  logic [1:0]  ld_ch;
  logic [15:0] ld_data;
  logic        frame_done, frame_err;
  logic [7:0]  last_cmd;
  state_e      dbg_state;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [15:0] exp_ch [4];

  adc_spi_responder dut (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .ld_valid(ld_valid), .ld_ch(ld_ch), .ld_data(ld_data),
    .frame_done(frame_done), .frame_err(frame_err), .last_cmd(last_cmd),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

  // driver tasks
  task automatic sck_pulse(input logic b, output logic s);
    mosi = b;
    repeat (5) @(negedge clk);
    s = miso;
    sck = 1'b1;
    repeat (5) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic spi_xfer(input logic [7:0] cmd, input int n_edges, input bit raise_cs,
                          input int ld_edge, input logic [1:0] lc, input logic [15:0] ldv,
                          output logic [15:0] data, output int stray);
    logic s;
    logic b;
    data = '0;
    stray = 0;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int e = 1; e <= n_edges; e++) begin
      b = (e <= 8) ? cmd[8-e] : 1'b0;
      sck_pulse(b, s);
      if (e >= 9 && e <= 24) data = {data[14:0], s};
      else if (s !== 1'b0) stray++;
      if (e == ld_edge) begin
        ld_valid = 1'b1;
        ld_ch    = lc;
        ld_data  = ldv;
        @(negedge clk);
        ld_valid = 1'b0;
      end
    end
    mosi = 1'b0;
    repeat (5) @(negedge clk);
    if (raise_cs) begin
      cs_n = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic load_ch(input logic [1:0] c, input logic [15:0] v);
    ld_valid = 1'b1;
    ld_ch    = c;
    ld_data  = v;
    @(negedge clk);
    ld_valid = 1'b0;
    exp_ch[c] = v;
  endtask

  task automatic model_done(input int c);
    if (RAMP) exp_ch[c] = exp_ch[c] + 16'd1;
  endtask

  task automatic model_reset();
    exp_ch[0] = 16'h1234;
    exp_ch[1] = 16'h5678;
    exp_ch[2] = 16'h9ABC;
    exp_ch[3] = 16'hDEF0;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    ld_valid = 1'b0; ld_ch = 2'd0; ld_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", miso); end
    checks++; if (last_cmd !== 8'h00) begin errors++; $display("FAIL reset_last_cmd: got %h expected 00", last_cmd); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    checks++; if (done_cnt !== 0 || err_cnt !== 0) begin errors++; $display("FAIL reset_pulses: got done=%0d err=%0d expected 0 0", done_cnt, err_cnt); end
  endtask

  task automatic test_basic();
    logic [15:0] d; int st; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    spi_xfer(8'h02, 24, 1'b1, 0, 2'd0, 16'h0, d, st);
    checks++; if (d !== 16'h9ABC) begin errors++; $display("FAIL basic_data: got %h expected 9abc", d); end
    checks++; if (last_cmd !== 8'h02) begin errors++; $display("FAIL basic_last_cmd: got %h expected 02", last_cmd); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done: got %0d pulses expected 1", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL basic_err: got %0d pulses expected 0", err_cnt - e0); end
    checks++; if (st !== 0) begin errors++; $display("FAIL basic_miso_idle: got %0d high samples expected 0", st); end
    model_done(2);
  endtask

  task automatic test_load_mid_frame();
    logic [15:0] d; int st;
    spi_xfer(8'h01, 24, 1'b1, 12, 2'd1, 16'hA5A5, d, st);
    exp_ch[1] = 16'hA5A5;
    checks++; if (d !== 16'h5678) begin errors++; $display("FAIL load_cur_frame: got %h expected 5678", d); end
    model_done(1);
    spi_xfer(8'h01, 24, 1'b1, 0, 2'd0, 16'h0, d, st);
    checks++; if (d !== exp_ch[1]) begin errors++; $display("FAIL load_next_frame: got %h expected %h", d, exp_ch[1]); end
    model_done(1);
  endtask

  task automatic test_abort();
    logic [15:0] d; int st; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    spi_xfer(8'h03, 12, 1'b1, 0, 2'd0, 16'h0, d, st);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL abort_data_err: got %0d pulses expected 1", err_cnt - e0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL abort_data_done: got %0d pulses expected 0", done_cnt - d0); end
    checks++; if (last_cmd !== 8'h03) begin errors++; $display("FAIL abort_data_last_cmd: got %h expected 03", last_cmd); end
    e0 = err_cnt;
    spi_xfer(8'h00, 4, 1'b1, 0, 2'd0, 16'h0, d, st);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL abort_cmd_err: got %0d pulses expected 1", err_cnt - e0); end
    checks++; if (last_cmd !== 8'h03) begin errors++; $display("FAIL abort_cmd_last_cmd: got %h expected 03", last_cmd); end
    d0 = done_cnt;
    spi_xfer(8'h03, 24, 1'b1, 0, 2'd0, 16'h0, d, st);
    checks++; if (d !== 16'hDEF0) begin errors++; $display("FAIL abort_recover_data: got %h expected def0", d); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL abort_recover_done: got %0d pulses expected 1", done_cnt - d0); end
    model_done(3);
  endtask

  task automatic test_long_frame();
    logic [15:0] d; int st; int d0;
    d0 = done_cnt;
    spi_xfer(8'h00, 30, 1'b1, 0, 2'd0, 16'h0, d, st);
    checks++; if (d !== 16'h1234) begin errors++; $display("FAIL long_data: got %h expected 1234", d); end
    checks++; if (st !== 0) begin errors++; $display("FAIL long_miso_tail: got %0d high samples expected 0", st); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL long_done: got %0d pulses expected 1", done_cnt - d0); end
    model_done(0);
  endtask

  task automatic test_repeat();
    logic [15:0] d; int st;
    for (int k = 0; k < 3; k++) begin
      spi_xfer(8'h03, 24, 1'b1, 0, 2'd0, 16'h0, d, st);
      checks++; if (d !== exp_ch[3]) begin errors++; $display("FAIL repeat_ch3_%0d: got %h expected %h", k, d, exp_ch[3]); end
      model_done(3);
    end
    load_ch(2'd0, 16'hFFFF);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      spi_xfer(8'h00, 24, 1'b1, 0, 2'd0, 16'h0, d, st);
      checks++; if (d !== exp_ch[0]) begin errors++; $display("FAIL repeat_ch0_%0d: got %h expected %h", k, d, exp_ch[0]); end
      model_done(0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] d; logic s; logic [7:0] c; int st; int d0, e0;
    c = 8'h02;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int e = 1; e <= 12; e++) sck_pulse((e <= 8) ? c[8-e] : 1'b0, s);
    d0 = done_cnt; e0 = err_cnt;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rstmid_miso: got %b expected 0", miso); end
    checks++; if (last_cmd !== 8'h00) begin errors++; $display("FAIL rstmid_last_cmd: got %h expected 00", last_cmd); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rstmid_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    rst = 1'b0;
    model_reset();
    st = 0;
    c = 8'h01;
    for (int e = 1; e <= 24; e++) begin
      sck_pulse((e <= 8) ? c[8-e] : 1'b0, s);
      if (s !== 1'b0) st++;
    end
    repeat (5) @(negedge clk);
    checks++; if (err_cnt - e0 !== 0 || done_cnt - d0 !== 0) begin errors++; $display("FAIL rstmid_pulses: got done=%0d err=%0d expected 0 0", done_cnt - d0, err_cnt - e0); end
    checks++; if (last_cmd !== 8'h00) begin errors++; $display("FAIL rstmid_no_frame_cmd: got %h expected 00", last_cmd); end
    checks++; if (st !== 0) begin errors++; $display("FAIL rstmid_no_frame_miso: got %0d high samples expected 0", st); end
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    d0 = done_cnt;
    spi_xfer(8'h01, 24, 1'b1, 0, 2'd0, 16'h0, d, st);
    checks++; if (d !== 16'h5678) begin errors++; $display("FAIL rstmid_recover_data: got %h expected 5678", d); end
    checks++; if (last_cmd !== 8'h01) begin errors++; $display("FAIL rstmid_recover_cmd: got %h expected 01", last_cmd); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rstmid_recover_done: got %0d pulses expected 1", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_mid_frame();
    test_abort();
    test_long_frame();
    test_repeat();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning sample width returned per frame.
REQ-002 SHALL have parameter CMD_W, default 8, meaning command bits received before data.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on sck/cs_n/mosi.
REQ-004 SHALL have port clk  input  1  system clock, one clock domain.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have ports sck, cs_n, mosi  input  1 each  SPI mode-0 bus from the SoC ADC master (asynchronous to clk).
REQ-007 SHALL have port miso  output  1  serial sample data, MSB first.
REQ-008 SHALL have ports ld_valid  input  1, ld_ch  input  2, ld_data  input  DATA_W  channel-value load strobe.
REQ-009 SHALL have port frame_done  output  1  one-clk pulse on complete frame.
REQ-010 SHALL have port frame_err  output  1  one-clk pulse on aborted frame.
REQ-011 SHALL have port last_cmd  output  CMD_W  last fully received command byte.

Function
REQ-012 SHALL sample sck, cs_n, mosi through SYNC_STAGES flops and detect edges on the synchronized values; clk SHALL be at least 8x sck.
REQ-013 SHALL implement states IDLE, CMD, DATA, TAIL.
REQ-014 IDLE->CMD on synchronized cs_n falling edge; bit counter cleared, miso=0.
REQ-015 CMD: shift mosi in on each sck rising edge, MSB first; on the CMD_W-th rising edge latch last_cmd, select channel last_cmd[1:0], load that channel's value into the shift register, drive its MSB on miso the next clk, go to DATA.
REQ-016 DATA: on each sck falling edge shift next bit onto miso; after DATA_W rising edges in DATA go to TAIL with miso=0.
REQ-017 TAIL: further sck edges ignored, miso=0; cs_n rising -> pulse frame_done, go IDLE.
REQ-018 cs_n rising in CMD or DATA SHALL pulse frame_err, leave last_cmd unchanged if in CMD, return to IDLE, suppress frame_done.
REQ-019 miso SHALL be 0 whenever state is IDLE or CMD or TAIL.
REQ-020 Four channel registers of DATA_W bits; ld_valid writes ld_data to channel ld_ch the next clk.
REQ-021 A load to the channel being shifted SHALL NOT alter the current frame; it applies from the next frame.
REQ-022 cs_n low at reset release SHALL NOT start a frame; a cs_n falling edge is required.

Reset
REQ-023 rst SHALL force: state IDLE, miso=0, frame_done=0, frame_err=0, last_cmd=0, counters 0, synchronizers to idle levels (sck=0, cs_n=1, mosi=0).
REQ-024 rst SHALL set channel registers to 0x1234, 0x5678, 0x9ABC, 0xDEF0 (ch0..ch3).
REQ-025 rst asserted mid-frame SHALL abort silently with no frame_err pulse.

Configuration
REQ-026 Macro ADC_RESP_RAMP_EN defined: on each frame_done the served channel register increments by 1, wrapping 0xFFFF->0x0000; ld_valid to the same channel in the same clk wins.
REQ-027 Macro ADC_RESP_RAMP_EN undefined: channel registers change only by ld_valid or rst.

Structure
REQ-028 Package adc_resp_pkg SHALL hold the state enum, CMD_W/DATA_W defaults, FRAME_BITS (24) and the four channel reset constants.
REQ-029 Sub-module sync_edge_det (SYNC_STAGES flops plus rise/fall pulse outputs) SHALL be instanced for sck, cs_n and mosi.

Verification
REQ-030 After reset, frame cmd 0x02 at sck = clk/10, 24 clocks -> miso bits 0x9ABC MSB first, last_cmd=0x02, one frame_done pulse.
REQ-031 ld_valid ch1 0xA5A5 mid-frame on ch1 -> current frame returns 0x5678, next ch1 frame returns 0xA5A5.
REQ-032 cs_n raised after 12 sck edges -> frame_err one pulse, no frame_done, next full frame returns correct value.
REQ-033 30 sck edges in one frame with cmd 0x00 -> data 0x1234, miso=0 during edges 25-30, single frame_done.
REQ-034 With ADC_RESP_RAMP_EN: three ch3 frames -> 0xDEF0, 0xDEF1, 0xDEF2; ch0 preloaded 0xFFFF -> 0xFFFF then 0x0000; without macro all repeats identical.
REQ-035 rst pulsed mid-DATA with cs_n held low -> outputs reset, no frame_err, no frame starts until cs_n high then low.
